// File: rtl/fox_network_interface.sv
// fox_network_interface: memory-mapped packet port for one Fox/Hoplite multicast node.
//   TX: per-field strobes load staging regs; packet_complete_in packs them into a TX FIFO
//       offered to the router client port (packet_out/_valid/_ready).
//   RX: router-ejected packets (packet_in/_valid/_ready) queue in an RX FIFO feeding a head
//       register whose fields are presented on *_out; message_in_read pops the head.
//   field_error: sticky missing-field flag, active only when PACKET_FIELD_CHECK_EN is defined.
//   Clock clk, asynchronous active-low reset reset_n.
module fox_network_interface #(
    parameter int COORD_BITS           = 1,
    parameter int MULTICAST_GROUP_BITS = 1,
    parameter int MATRIX_TYPE_BITS     = 1,
    parameter int MATRIX_COORD_BITS    = 8,
    parameter int MATRIX_ELEMENT_BITS  = 32,
    parameter int TX_FIFO_DEPTH        = 4,
    parameter int RX_FIFO_DEPTH        = 4,
    localparam int PACKET_BITS = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 + MATRIX_TYPE_BITS
                               + 2*MATRIX_COORD_BITS + MATRIX_ELEMENT_BITS
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [COORD_BITS-1:0]           x_coord_in,
    input  logic                            x_coord_in_valid,
    input  logic [COORD_BITS-1:0]           y_coord_in,
    input  logic                            y_coord_in_valid,
    input  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_in,
    input  logic                            multicast_group_in_valid,
    input  logic                            done_flag_in,
    input  logic                            done_flag_in_valid,
    input  logic                            result_flag_in,
    input  logic                            result_flag_in_valid,
    input  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_in,
    input  logic                            matrix_type_in_valid,
    input  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_in,
    input  logic                            matrix_x_coord_in_valid,
    input  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_in,
    input  logic                            matrix_y_coord_in_valid,
    input  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_in,
    input  logic                            matrix_element_in_valid,
    input  logic                            packet_complete_in,
    output logic                            message_out_ready,
    output logic [PACKET_BITS-1:0]          packet_out,
    output logic                            packet_out_valid,
    input  logic                            packet_out_ready,
    input  logic [PACKET_BITS-1:0]          packet_in,
    input  logic                            packet_in_valid,
    output logic                            packet_in_ready,
    output logic [MULTICAST_GROUP_BITS-1:0] multicast_group_out,
    output logic                            done_flag_out,
    output logic                            result_flag_out,
    output logic [MATRIX_TYPE_BITS-1:0]     matrix_type_out,
    output logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_out,
    output logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_out,
    output logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_out,
    output logic                            message_in_valid,
    output logic                            message_in_available,
    input  logic                            message_in_read,
    output logic                            field_error
);
    // Field LSB positions inside a packet word; x/y occupy the top and are not kept on RX.
    localparam int P_MY = MATRIX_ELEMENT_BITS;
    localparam int P_MX = P_MY + MATRIX_COORD_BITS;
    localparam int P_T  = P_MX + MATRIX_COORD_BITS;
    localparam int P_R  = P_T + MATRIX_TYPE_BITS;
    localparam int P_D  = P_R + 1;
    localparam int P_G  = P_D + 1;
    localparam int P_Y  = P_G + MULTICAST_GROUP_BITS;
    localparam int TAW  = $clog2(TX_FIFO_DEPTH);
    localparam int RAW  = $clog2(RX_FIFO_DEPTH);

    logic [COORD_BITS-1:0]           x_q, x_d, y_q, y_d;
    logic [MULTICAST_GROUP_BITS-1:0] g_q, g_d;
    logic                            dn_q, dn_d, rs_q, rs_d;
    logic [MATRIX_TYPE_BITS-1:0]     t_q, t_d;
    logic [MATRIX_COORD_BITS-1:0]    mx_q, mx_d, my_q, my_d;
    logic [MATRIX_ELEMENT_BITS-1:0]  e_q, e_d;
    logic [PACKET_BITS-1:0]          tx_mem [TX_FIFO_DEPTH];
    logic [TAW-1:0]                  tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [TAW:0]                    tx_cnt_q, tx_cnt_d;
    logic [P_Y-1:0]                  rx_mem [RX_FIFO_DEPTH];
    logic [RAW-1:0]                  rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [RAW:0]                    rx_cnt_q, rx_cnt_d;
    logic [P_Y-1:0]                  head_q, head_d;
    logic                            hv_q, hv_d;
    logic                            fields_ok, tx_full, tx_push, tx_pop;
    logic                            rx_full, rx_acc, rx_rd, rx_load;

    // Staging next values: a coincident strobe is what gets packed.
    always_comb begin
        x_d  = x_coord_in_valid        ? x_coord_in        : x_q;
        y_d  = y_coord_in_valid        ? y_coord_in        : y_q;
        g_d  = multicast_group_in_valid ? multicast_group_in : g_q;
        dn_d = done_flag_in_valid      ? done_flag_in      : dn_q;
        rs_d = result_flag_in_valid    ? result_flag_in    : rs_q;
        t_d  = matrix_type_in_valid    ? matrix_type_in    : t_q;
        mx_d = matrix_x_coord_in_valid ? matrix_x_coord_in : mx_q;
        my_d = matrix_y_coord_in_valid ? matrix_y_coord_in : my_q;
        e_d  = matrix_element_in_valid ? matrix_element_in : e_q;
    end

`ifdef PACKET_FIELD_CHECK_EN
    logic [8:0] wr_q, wr_d, wr_n;
    logic       err_q, err_d;
    always_comb begin
        wr_n = wr_q | {x_coord_in_valid, y_coord_in_valid, multicast_group_in_valid,
                       done_flag_in_valid, result_flag_in_valid, matrix_type_in_valid,
                       matrix_x_coord_in_valid, matrix_y_coord_in_valid, matrix_element_in_valid};
        fields_ok = &wr_n;
        wr_d = packet_complete_in ? 9'd0 : wr_n;
        err_d = err_q | (packet_complete_in & ~fields_ok);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            err_q <= err_d;
        end
    end
    assign field_error = err_q;
`else
    assign fields_ok   = 1'b1;
    assign field_error = 1'b0;
`endif

    always_comb begin
        tx_full  = tx_cnt_q == (TAW+1)'(TX_FIFO_DEPTH);
        tx_push  = packet_complete_in & ~tx_full & fields_ok;
        tx_pop   = (tx_cnt_q != '0) & packet_out_ready;
        tx_wp_d  = tx_wp_q + TAW'(tx_push);
        tx_rp_d  = tx_rp_q + TAW'(tx_pop);
        tx_cnt_d = tx_cnt_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
        rx_full  = rx_cnt_q == (RAW+1)'(RX_FIFO_DEPTH);
        rx_acc   = packet_in_valid & ~rx_full;
        rx_rd    = message_in_read & hv_q;
        // Head refills from the FIFO whenever it is empty or being popped.
        rx_load  = (rx_cnt_q != '0) & (~hv_q | rx_rd);
        rx_wp_d  = rx_wp_q + RAW'(rx_acc);
        rx_rp_d  = rx_rp_q + RAW'(rx_load);
        rx_cnt_d = rx_cnt_q + (RAW+1)'(rx_acc) - (RAW+1)'(rx_load);
        head_d   = rx_load ? rx_mem[rx_rp_q] : head_q;
        hv_d     = rx_load | (hv_q & ~rx_rd);
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= {x_d, y_d, g_d, dn_d, rs_d, t_d, mx_d, my_d, e_d};
        if (rx_acc)  rx_mem[rx_wp_q] <= packet_in[P_Y-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q <= '0; y_q <= '0; g_q <= '0; dn_q <= 1'b0; rs_q <= 1'b0;
            t_q <= '0; mx_q <= '0; my_q <= '0; e_q <= '0;
            tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
            rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
            head_q <= '0; hv_q <= 1'b0;
        end else begin
            x_q <= x_d; y_q <= y_d; g_q <= g_d; dn_q <= dn_d; rs_q <= rs_d;
            t_q <= t_d; mx_q <= mx_d; my_q <= my_d; e_q <= e_d;
            tx_wp_q <= tx_wp_d; tx_rp_q <= tx_rp_d; tx_cnt_q <= tx_cnt_d;
            rx_wp_q <= rx_wp_d; rx_rp_q <= rx_rp_d; rx_cnt_q <= rx_cnt_d;
            head_q <= head_d; hv_q <= hv_d;
        end
    end

    // Gate the head with valid so uninitialised memory never reaches the router.
    assign packet_out_valid     = tx_cnt_q != '0;
    assign packet_out           = packet_out_valid ? tx_mem[tx_rp_q] : '0;
    assign message_out_ready    = ~tx_full;
    assign packet_in_ready      = ~rx_full;
    assign message_in_valid     = hv_q;
    assign message_in_available = hv_q | (rx_cnt_q != '0);
    assign multicast_group_out  = head_q[P_Y-1:P_G];
    assign done_flag_out        = head_q[P_D];
    assign result_flag_out      = head_q[P_R];
    assign matrix_type_out      = head_q[P_R-1:P_T];
    assign matrix_x_coord_out   = head_q[P_T-1:P_MX];
    assign matrix_y_coord_out   = head_q[P_MX-1:P_MY];
    assign matrix_element_out   = head_q[P_MY-1:0];
endmodule

// File: tb/tb_fox_network_interface.sv
// tb_fox_network_interface: directed self-checking bench for fox_network_interface.
module tb_fox_network_interface;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        x_coord_in = 0, x_coord_in_valid = 0, y_coord_in = 0, y_coord_in_valid = 0;
    logic        multicast_group_in = 0, multicast_group_in_valid = 0;
    logic        done_flag_in = 0, done_flag_in_valid = 0, result_flag_in = 0, result_flag_in_valid = 0;
    logic        matrix_type_in = 0, matrix_type_in_valid = 0;
    logic [7:0]  matrix_x_coord_in = 0, matrix_y_coord_in = 0;
    logic        matrix_x_coord_in_valid = 0, matrix_y_coord_in_valid = 0;
    logic [31:0] matrix_element_in = 0;
    logic        matrix_element_in_valid = 0, packet_complete_in = 0;
    logic        message_out_ready, packet_out_valid, packet_out_ready = 0;
    logic [53:0] packet_out, packet_in = 0;
    logic        packet_in_valid = 0, packet_in_ready;
    logic        multicast_group_out, done_flag_out, result_flag_out, matrix_type_out;
    logic [7:0]  matrix_x_coord_out, matrix_y_coord_out;
    logic [31:0] matrix_element_out;
    logic        message_in_valid, message_in_available, message_in_read = 0, field_error;
    int          vec = 0, errs = 0;

    fox_network_interface dut (
        .clk(clk), .reset_n(reset_n),
        .x_coord_in(x_coord_in), .x_coord_in_valid(x_coord_in_valid),
        .y_coord_in(y_coord_in), .y_coord_in_valid(y_coord_in_valid),
        .multicast_group_in(multicast_group_in), .multicast_group_in_valid(multicast_group_in_valid),
        .done_flag_in(done_flag_in), .done_flag_in_valid(done_flag_in_valid),
        .result_flag_in(result_flag_in), .result_flag_in_valid(result_flag_in_valid),
        .matrix_type_in(matrix_type_in), .matrix_type_in_valid(matrix_type_in_valid),
        .matrix_x_coord_in(matrix_x_coord_in), .matrix_x_coord_in_valid(matrix_x_coord_in_valid),
        .matrix_y_coord_in(matrix_y_coord_in), .matrix_y_coord_in_valid(matrix_y_coord_in_valid),
        .matrix_element_in(matrix_element_in), .matrix_element_in_valid(matrix_element_in_valid),
        .packet_complete_in(packet_complete_in), .message_out_ready(message_out_ready),
        .packet_out(packet_out), .packet_out_valid(packet_out_valid), .packet_out_ready(packet_out_ready),
        .packet_in(packet_in), .packet_in_valid(packet_in_valid), .packet_in_ready(packet_in_ready),
        .multicast_group_out(multicast_group_out), .done_flag_out(done_flag_out),
        .result_flag_out(result_flag_out), .matrix_type_out(matrix_type_out),
        .matrix_x_coord_out(matrix_x_coord_out), .matrix_y_coord_out(matrix_y_coord_out),
        .matrix_element_out(matrix_element_out), .message_in_valid(message_in_valid),
        .message_in_available(message_in_available), .message_in_read(message_in_read),
        .field_error(field_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        {x_coord_in_valid, y_coord_in_valid, multicast_group_in_valid, done_flag_in_valid,
         result_flag_in_valid, matrix_type_in_valid, matrix_x_coord_in_valid,
         matrix_y_coord_in_valid, matrix_element_in_valid, packet_complete_in} = '0;
    endtask

    task automatic strobe_all(input logic [53:0] w);
        {x_coord_in, y_coord_in, multicast_group_in, done_flag_in, result_flag_in, matrix_type_in,
         matrix_x_coord_in, matrix_y_coord_in, matrix_element_in} = w;
        {x_coord_in_valid, y_coord_in_valid, multicast_group_in_valid, done_flag_in_valid,
         result_flag_in_valid, matrix_type_in_valid, matrix_x_coord_in_valid,
         matrix_y_coord_in_valid, matrix_element_in_valid} = '1;
    endtask

    // Strobe all fields together with complete in one cycle.
    task automatic send(input logic [53:0] w);
        strobe_all(w);
        packet_complete_in = 1'b1;
        tick;
        clr;
    endtask

    function automatic logic [53:0] elem_pkt(input logic [31:0] e);
        return {6'b011010, 8'h11, 8'h22, e};
    endfunction

    initial begin
        logic [53:0] w;
        int n;
        // Reset state
        tick;
        chk("rst_pov", packet_out_valid, 0);
        chk("rst_mor", message_out_ready, 1);
        chk("rst_pir", packet_in_ready, 1);
        chk("rst_miv", message_in_valid, 0);
        chk("rst_mia", message_in_available, 0);
        chk("rst_ferr", field_error, 0);
        chk("rst_elem", matrix_element_out, 0);
        reset_n = 1'b1;
        tick;

        // 1: strobes, then complete, then handshake
        strobe_all({6'b101001, 8'd3, 8'd5, 32'hDEADBEEF});
        tick;
        clr;
        packet_complete_in = 1'b1;
        tick;
        packet_complete_in = 1'b0;
        chk("t1_valid", packet_out_valid, 1);
        chk("t1_pkt", packet_out, 54'h29_0305_DEADBEEF);
        packet_out_ready = 1'b1;
        tick;
        chk("t1_popped", packet_out_valid, 0);
        packet_out_ready = 1'b0;

        // 2: fill TX to full, drop the fifth, drain in order
        for (int i = 0; i < 4; i++) send(elem_pkt(100 + i));
        chk("t2_full", message_out_ready, 0);
        send(elem_pkt(104));
        chk("t2_still_full", message_out_ready, 0);
        packet_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", packet_out, elem_pkt(100 + i));
            tick;
        end
        chk("t2_empty", packet_out_valid, 0);
        chk("t2_mor", message_out_ready, 1);
        packet_out_ready = 1'b0;

        // 3: inject five packets with no reads, then read back-to-back
        for (int i = 0; i < 5; i++) begin
            packet_in = elem_pkt(200 + i);
            packet_in_valid = 1'b1;
            n = 0;
            while (!packet_in_ready && n < 20) begin
                tick;
                n++;
            end
            chk("t3_rdy", packet_in_ready, 1);
            tick;
        end
        packet_in_valid = 1'b0;
        chk("t3_backpress", packet_in_ready, 0);
        message_in_read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_miv", message_in_valid, 1);
            chk("t3_elem", matrix_element_out, 200 + i);
            tick;
        end
        message_in_read = 1'b0;
        chk("t3_miv_end", message_in_valid, 0);
        chk("t3_mia_end", message_in_available, 0);

        // 4: single packet latency and field decode
        packet_in = {6'b001101, 8'hAA, 8'h55, 32'h12345678};
        packet_in_valid = 1'b1;
        tick;
        packet_in_valid = 1'b0;
        chk("t4_miv_n", message_in_valid, 0);
        chk("t4_mia_n", message_in_available, 1);
        tick;
        chk("t4_miv_n1", message_in_valid, 1);
        chk("t4_elem", matrix_element_out, 32'h12345678);
        chk("t4_grp", multicast_group_out, 1);
        chk("t4_done", done_flag_out, 1);
        chk("t4_res", result_flag_out, 0);
        chk("t4_type", matrix_type_out, 1);
        chk("t4_mx", matrix_x_coord_out, 8'hAA);
        chk("t4_my", matrix_y_coord_out, 8'h55);
        message_in_read = 1'b1;
        tick;
        message_in_read = 1'b0;
        chk("t4_miv_rd", message_in_valid, 0);
        chk("t4_mia_rd", message_in_available, 0);
        message_in_read = 1'b1;
        tick;
        message_in_read = 1'b0;
        chk("t4_read_empty", message_in_valid, 0);

        // 5: TX push+pop in one cycle, RX accept+reload in one cycle
        for (int i = 0; i < 3; i++) send(elem_pkt(300 + i));
        packet_out_ready = 1'b1;
        chk("t5_head", packet_out, elem_pkt(300));
        send(elem_pkt(303));
        chk("t5_mor", message_out_ready, 1);
        for (int i = 1; i < 4; i++) begin
            chk("t5_order", packet_out, elem_pkt(300 + i));
            tick;
        end
        chk("t5_empty", packet_out_valid, 0);
        packet_out_ready = 1'b0;
        packet_in_valid = 1'b1;
        packet_in = elem_pkt(400);
        tick;
        packet_in = elem_pkt(401);
        tick;
        packet_in = elem_pkt(402);
        message_in_read = 1'b1;
        tick;
        packet_in_valid = 1'b0;
        chk("t5_rx_b", matrix_element_out, 401);
        chk("t5_rx_bv", message_in_valid, 1);
        tick;
        chk("t5_rx_c", matrix_element_out, 402);
        chk("t5_rx_cv", message_in_valid, 1);
        tick;
        message_in_read = 1'b0;
        chk("t5_rx_done", message_in_valid, 0);
        chk("t5_rx_avail", message_in_available, 0);

        // Asynchronous reset mid-operation discards queued packets
        send(elem_pkt(500));
        packet_in = elem_pkt(501);
        packet_in_valid = 1'b1;
        tick;
        packet_in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_pov", packet_out_valid, 0);
        chk("rst_mid_mia", message_in_available, 0);
        tick;
        reset_n = 1'b1;
        tick;

        // 6: complete after only x,y strobes
        x_coord_in = 1'b1; x_coord_in_valid = 1'b1;
        y_coord_in = 1'b1; y_coord_in_valid = 1'b1;
        packet_complete_in = 1'b1;
        tick;
        clr;
`ifdef PACKET_FIELD_CHECK_EN
        chk("t6_nopush", packet_out_valid, 0);
        chk("t6_ferr", field_error, 1);
        send(elem_pkt(600));
        chk("t6_push_ok", packet_out_valid, 1);
        chk("t6_ferr_sticky", field_error, 1);
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        chk("t6_ferr_rst", field_error, 0);
`else
        chk("t6_push", packet_out_valid, 1);
        chk("t6_stale", packet_out, {2'b11, 52'd0});
        chk("t6_ferr", field_error, 0);
`endif
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
